// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: req/ack data-bus access, store lane formatting, load extension, MEM/WB register.
// Optional `LSU_MISALIGN_TRAP_EN enables misaligned-access exceptions instead of lane-aligned bus accesses.
module mem_stage_lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_insn_vld,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [2:0]  i_ld_en,
  input  logic        i_lsu_wren,
  input  logic        i_rd_wren,
  input  logic [1:0]  i_wb_sel,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_insn_vld,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_rd_wren,
  output logic [1:0]  o_wb_sel,
  output logic [31:0] o_alu_data,
  output logic [31:0] o_ld_data,
  output logic        o_lsu_exc,
  output logic [3:0]  o_exc_cause,
  output logic [31:0] o_exc_tval
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t      state_r;
  logic [2:0]  ld_en_r;
  logic [1:0]  lane_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        rd_wren_r;
  logic [1:0]  wb_sel_r;
  logic [31:0] alu_r;

  logic        is_load_s;
  logic [1:0]  size_s;      // 0 byte, 1 half, 2 word
  logic [1:0]  lane_s;
  logic        mem_op_s;
  logic        misalign_s;
  logic        issue_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;

  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [2:0]  ld_en,
                                               input logic [1:0]  lane);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {lane, 3'b000};
    case (ld_en)
      3'b001:  res = {{24{sh[7]}}, sh[7:0]};
      3'b010:  res = {{16{sh[15]}}, sh[15:0]};
      3'b011:  res = sh;
      3'b101:  res = {24'h000000, sh[7:0]};
      3'b110:  res = {16'h0000, sh[15:0]};
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  // Decode access size, lane, byte enables, store data and misalignment
  always_comb begin
    is_load_s = 1'b0;
    size_s    = 2'd2;
    case (i_ld_en)
      3'b001, 3'b101: begin is_load_s = 1'b1; size_s = 2'd0; end
      3'b010, 3'b110: begin is_load_s = 1'b1; size_s = 2'd1; end
      3'b011:         begin is_load_s = 1'b1; size_s = 2'd2; end
      default: begin
        is_load_s = 1'b0;
        case (i_instr[13:12])
          2'b00:   size_s = 2'd0;
          2'b01:   size_s = 2'd1;
          default: size_s = 2'd2;   // size 11 behaves as a word store
        endcase
      end
    endcase
    mem_op_s = i_insn_vld & (is_load_s | i_lsu_wren);
    // Halfwords and words always use naturally aligned lanes; only bytes honour addr[1:0] fully
    case (size_s)
      2'd0:    begin lane_s = i_alu_data[1:0];       be_s = 4'b0001 << i_alu_data[1:0];
                     wdata_s = {4{i_rs2_data[7:0]}}; end
      2'd1:    begin lane_s = {i_alu_data[1], 1'b0}; be_s = 4'b0011 << {i_alu_data[1], 1'b0};
                     wdata_s = {2{i_rs2_data[15:0]}}; end
      default: begin lane_s = 2'b00;                 be_s = 4'b1111;
                     wdata_s = i_rs2_data; end
    endcase
    be_s = is_load_s ? 4'b1111 : be_s;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_s = mem_op_s & (((size_s == 2'd1) & i_alu_data[0]) |
                             ((size_s == 2'd2) & (i_alu_data[1:0] != 2'b00)));
`else
    misalign_s = 1'b0;
`endif
    issue_s = mem_op_s & ~misalign_s;
    o_stall = (state_r == ST_IDLE) ? issue_s : ~i_dmem_ack;
  end

  // Access FSM, bus request registers and MEM/WB boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ST_IDLE;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= 32'h00000000;
      o_dmem_wdata <= 32'h00000000;
      o_dmem_be    <= 4'b0000;
      ld_en_r      <= 3'b000;
      lane_r       <= 2'b00;
      pc_r         <= 32'h00000000;
      instr_r      <= 32'h00000013;
      rd_wren_r    <= 1'b0;
      wb_sel_r     <= 2'b00;
      alu_r        <= 32'h00000000;
      o_insn_vld   <= 1'b0;
      o_pc         <= 32'h00000000;
      o_instr      <= 32'h00000013;
      o_rd_wren    <= 1'b0;
      o_wb_sel     <= 2'b00;
      o_alu_data   <= 32'h00000000;
      o_ld_data    <= 32'h00000000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_pc       <= i_pc;
          o_instr    <= i_instr;
          o_wb_sel   <= i_wb_sel;
          o_alu_data <= i_alu_data;
          o_ld_data  <= 32'h00000000;
          if (issue_s) begin
            state_r      <= ST_BUSY;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= ~is_load_s;
            o_dmem_addr  <= {i_alu_data[31:2], 2'b00};
            o_dmem_wdata <= wdata_s;
            o_dmem_be    <= be_s;
            ld_en_r      <= is_load_s ? i_ld_en : 3'b000;
            lane_r       <= lane_s;
            pc_r         <= i_pc;
            instr_r      <= i_instr;
            rd_wren_r    <= i_rd_wren;
            wb_sel_r     <= i_wb_sel;
            alu_r        <= i_alu_data;
            o_insn_vld   <= 1'b0;
            o_rd_wren    <= 1'b0;
          end else if (misalign_s) begin
            o_insn_vld <= 1'b0;
            o_rd_wren  <= 1'b0;
          end else begin
            o_insn_vld <= i_insn_vld;
            o_rd_wren  <= i_rd_wren;
          end
        end
        ST_BUSY: begin
          if (i_dmem_ack) begin
            state_r    <= ST_IDLE;
            o_dmem_req <= 1'b0;
            o_insn_vld <= 1'b1;
            o_pc       <= pc_r;
            o_instr    <= instr_r;
            o_rd_wren  <= rd_wren_r;
            o_wb_sel   <= wb_sel_r;
            o_alu_data <= alu_r;
            o_ld_data  <= extract_load(i_dmem_rdata, ld_en_r, lane_r);
          end else begin
            state_r <= ST_BUSY;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          o_dmem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned-access exception pulse with cause and faulting address
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lsu_exc   <= 1'b0;
      o_exc_cause <= 4'd0;
      o_exc_tval  <= 32'h00000000;
    end else if ((state_r == ST_IDLE) && misalign_s) begin
      o_lsu_exc   <= 1'b1;
      o_exc_cause <= is_load_s ? 4'd4 : 4'd6;
      o_exc_tval  <= i_alu_data;
    end else begin
      o_lsu_exc   <= 1'b0;
    end
  end
`else
  assign o_lsu_exc   = 1'b0;
  assign o_exc_cause = 4'd0;
  assign o_exc_tval  = 32'h00000000;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: byte-level reference model plus per-cycle stall/bus-hold monitor.
module tb_mem_stage_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_insn_vld;
  logic [31:0] i_pc, i_instr, i_alu_data, i_rs2_data, i_dmem_rdata;
  logic [2:0]  i_ld_en;
  logic        i_lsu_wren, i_rd_wren, i_dmem_ack;
  logic [1:0]  i_wb_sel;
  logic        o_stall, o_dmem_req, o_dmem_we, o_insn_vld, o_rd_wren, o_lsu_exc;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_pc, o_instr, o_alu_data, o_ld_data, o_exc_tval;
  logic [3:0]  o_dmem_be, o_exc_cause;
  logic [1:0]  o_wb_sel;

  mem_stage_lsu dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_insn_vld(i_insn_vld), .i_pc(i_pc), .i_instr(i_instr),
    .i_ld_en(i_ld_en), .i_lsu_wren(i_lsu_wren), .i_rd_wren(i_rd_wren), .i_wb_sel(i_wb_sel),
    .i_alu_data(i_alu_data), .i_rs2_data(i_rs2_data), .o_stall(o_stall),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .o_insn_vld(o_insn_vld), .o_pc(o_pc), .o_instr(o_instr),
    .o_rd_wren(o_rd_wren), .o_wb_sel(o_wb_sel), .o_alu_data(o_alu_data),
    .o_ld_data(o_ld_data), .o_lsu_exc(o_lsu_exc), .o_exc_cause(o_exc_cause),
    .o_exc_tval(o_exc_tval)
  );

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic bit f_isld(input logic [2:0] ld);
    return ld inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  endfunction

  function automatic int f_size(input logic [2:0] ld, input logic [31:0] ins);
    if (f_isld(ld)) return (ld == 3'd3) ? 4 : ((ld == 3'd2 || ld == 3'd6) ? 2 : 1);
    return (ins[13:12] == 2'b00) ? 1 : ((ins[13:12] == 2'b01) ? 2 : 4);
  endfunction

  function automatic int f_off(input logic [31:0] addr, input int sz);
    int a;
    a = int'(addr[1:0]);
    if (sz == 1) return a;
    if (sz == 2) return (a / 2) * 2;
    return 0;
  endfunction

  function automatic bit f_mis(input logic [31:0] addr, input int sz);
`ifdef LSU_MISALIGN_TRAP_EN
    return (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] f_be(input logic [31:0] addr, input int sz, input bit isld);
    logic [3:0] be;
    int off;
    off = f_off(addr, sz);
    for (int k = 0; k < 4; k++) be[k] = isld || (k >= off && k < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [31:0] rs2, input int sz);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = rs2[8*(k % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] f_ld(input logic [31:0] rdata, input logic [31:0] addr,
                                       input logic [2:0] ld);
    logic [31:0] v;
    int sz, off;
    sz  = f_size(ld, 32'h0);
    off = f_off(addr, sz);
    v   = 32'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if ((ld == 3'd1 || ld == 3'd2) && v[8*sz-1]) v = v | (32'hFFFFFFFF << (8*sz));
    return v;
  endfunction

  // ---------------- per-cycle monitor: stall and bus hold ----------------
  logic        exp_stall = 1'b0;
  bit          mon_en = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic [4:0]  prev_bew;
  int          stall_cnt = 0;

  always @(negedge i_clk) begin
    if (mon_en) begin
      chk("stall", 32'(o_stall), 32'(exp_stall));
      if (o_stall) stall_cnt++;
      if (o_dmem_req && prev_req) begin
        chk("hold_addr", o_dmem_addr, prev_addr);
        chk("hold_wdata", o_dmem_wdata, prev_wdata);
        chk("hold_be_we", 32'({o_dmem_be, o_dmem_we}), 32'(prev_bew));
      end
    end
    prev_req   = o_dmem_req;
    prev_addr  = o_dmem_addr;
    prev_wdata = o_dmem_wdata;
    prev_bew   = {o_dmem_be, o_dmem_we};
  end

  // ---------------- driver: one instruction, called at posedge+1 ----------------
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  task automatic run_op(input logic vld, input logic [31:0] pc, input logic [31:0] ins,
                        input logic [2:0] ld, input logic st, input logic rdw,
                        input logic [1:0] wbs, input logic [31:0] alu, input logic [31:0] rs2,
                        input int waits, input logic [31:0] rdata);
    bit isld, memop, mis;
    int sz;
    i_insn_vld = vld; i_pc = pc; i_instr = ins; i_ld_en = ld; i_lsu_wren = st;
    i_rd_wren = rdw; i_wb_sel = wbs; i_alu_data = alu; i_rs2_data = rs2;
    isld  = f_isld(ld);
    sz    = f_size(ld, ins);
    memop = vld && (isld || st);
    mis   = memop && f_mis(alu, sz);
    exp_stall = memop && !mis;
    @(posedge i_clk); #1;
    if (!memop || mis) begin
      chk("req_idle", 32'(o_dmem_req), 32'd0);
      chk("vld", 32'(o_insn_vld), mis ? 32'd0 : 32'(vld));
      chk("rd_wren", 32'(o_rd_wren), mis ? 32'd0 : 32'(rdw));
      chk("pc", o_pc, pc);
      chk("alu", o_alu_data, alu);
      chk("ld_data_nonload", o_ld_data, 32'h0);
      chk("exc", 32'(o_lsu_exc), 32'(mis));
      if (mis) begin
        chk("cause", 32'(o_exc_cause), isld ? 32'd4 : 32'd6);
        chk("tval", o_exc_tval, alu);
      end
    end else begin
      chk("req_issue", 32'(o_dmem_req), 32'd1);
      chk("addr", o_dmem_addr, alu & 32'hFFFFFFFC);
      chk("we", 32'(o_dmem_we), 32'(!isld));
      chk("be", 32'(o_dmem_be), 32'(f_be(alu, sz, isld)));
      if (!isld) chk("wdata", o_dmem_wdata, f_wdata(rs2, sz));
      chk("bubble_vld", 32'(o_insn_vld), 32'd0);
      chk("bubble_rd_wren", 32'(o_rd_wren), 32'd0);
      chk("exc_none", 32'(o_lsu_exc), 32'd0);
      last_addr = o_dmem_addr; last_wdata = o_dmem_wdata; last_be = o_dmem_be; last_we = o_dmem_we;
      exp_stall = 1'b1;
      repeat (waits) begin
        @(posedge i_clk); #1;
        chk("busy_req", 32'(o_dmem_req), 32'd1);
        chk("busy_vld", 32'(o_insn_vld), 32'd0);
      end
      i_dmem_ack = 1'b1; i_dmem_rdata = rdata; exp_stall = 1'b0;
      @(posedge i_clk); #1;
      i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
      chk("ret_vld", 32'(o_insn_vld), 32'd1);
      chk("ret_rd_wren", 32'(o_rd_wren), 32'(rdw));
      chk("ret_pc", o_pc, pc);
      chk("ret_instr", o_instr, ins);
      chk("ret_wb_sel", 32'(o_wb_sel), 32'(wbs));
      chk("ret_alu", o_alu_data, alu);
      chk("ret_ld_data", o_ld_data, isld ? f_ld(rdata, alu, ld) : 32'h0);
      chk("ret_req_drop", 32'(o_dmem_req), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_insn_vld = 1'b0; i_pc = 32'h0; i_instr = 32'h0; i_ld_en = 3'd0;
    i_lsu_wren = 1'b0; i_rd_wren = 1'b0; i_wb_sel = 2'd0; i_alu_data = 32'h0;
    i_rs2_data = 32'h0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'h0;
    #12;
    chk("rst_instr", o_instr, 32'h00000013);
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_vld", 32'(o_insn_vld), 32'd0);
    chk("rst_ld_data", o_ld_data, 32'h0);
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    mon_en = 1'b1;

    // ADDI passthrough
    stall_cnt = 0;
    run_op(1'b1, 32'h100, 32'h05500093, 3'd0, 1'b0, 1'b1, 2'd1, 32'h55, 32'h0, 0, 32'h0);
    chk("addi_alu_lit", o_alu_data, 32'h55);
    chk("addi_vld_lit", 32'(o_insn_vld), 32'd1);
    chk("addi_stall_cnt", 32'(stall_cnt), 32'd0);

    // LB sign extension with 3 wait cycles
    stall_cnt = 0;
    run_op(1'b1, 32'h104, 32'h00300083, 3'd1, 1'b0, 1'b1, 2'd1, 32'h1003, 32'h0, 3, 32'h80AABBCC);
    chk("lb_addr_lit", last_addr, 32'h1000);
    chk("lb_ld_lit", o_ld_data, 32'hFFFFFF80);
    chk("lb_stall_cnt", 32'(stall_cnt), 32'd4);

    // SH lane placement
    run_op(1'b1, 32'h108, 32'h00B11123, 3'd0, 1'b1, 1'b0, 2'd0, 32'h2002, 32'h1234ABCD, 1, 32'h0);
    chk("sh_be_lit", 32'(last_be), 32'hC);
    chk("sh_wdata_lit", last_wdata, 32'hABCDABCD);
    chk("sh_we_lit", 32'(last_we), 32'd1);

    // Misaligned LW
    run_op(1'b1, 32'h10C, 32'h00012083, 3'd3, 1'b0, 1'b1, 2'd1, 32'h3001, 32'h0, 0, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_cause_lit", 32'(o_exc_cause), 32'd4);
    chk("mis_tval_lit", o_exc_tval, 32'h3001);
    chk("mis_rd_wren_lit", 32'(o_rd_wren), 32'd0);
`else
    chk("mis_addr_lit", last_addr, 32'h3000);
    chk("mis_exc_lit", 32'(o_lsu_exc), 32'd0);
`endif
    // Misaligned SH (store cause in trap build, low-half lanes otherwise)
    run_op(1'b1, 32'h110, 32'h00111023, 3'd0, 1'b1, 1'b0, 2'd0, 32'h5001, 32'hCAFE1357, 0, 32'h0);

    // Back-to-back zero-wait accesses
    run_op(1'b1, 32'h114, 32'h00012083, 3'd3, 1'b0, 1'b1, 2'd1, 32'h4000, 32'h0, 0, 32'hDEADBEEF);
    chk("lw_ld_lit", o_ld_data, 32'hDEADBEEF);
    run_op(1'b1, 32'h118, 32'h00112023, 3'd0, 1'b1, 1'b0, 2'd0, 32'h4004, 32'hCAFEF00D, 0, 32'h0);
    run_op(1'b1, 32'h11C, 32'h00015083, 3'd6, 1'b0, 1'b1, 2'd1, 32'h4006, 32'h0, 0, 32'h87654321);
    chk("lhu_ld_lit", o_ld_data, 32'h00008765);
    run_op(1'b1, 32'h120, 32'h00014083, 3'd5, 1'b0, 1'b1, 2'd1, 32'h4001, 32'h0, 0, 32'h000AB100);
    chk("lbu_ld_lit", o_ld_data, 32'h000000B1);
    run_op(1'b1, 32'h124, 32'h00011083, 3'd2, 1'b0, 1'b1, 2'd1, 32'h4002, 32'h0, 1, 32'h80010000);
    chk("lh_ld_lit", o_ld_data, 32'hFFFF8001);
    run_op(1'b1, 32'h128, 32'h00110023, 3'd0, 1'b1, 1'b0, 2'd0, 32'h4003, 32'h000000AB, 0, 32'h0);
    chk("sb_be_lit", 32'(last_be), 32'h8);
    chk("sb_wdata_lit", last_wdata, 32'hABABABAB);
    // Store size 11 behaves as SW; reserved ld_en is a non-load; invalid slot is a bubble
    run_op(1'b1, 32'h12C, 32'h00113023, 3'd0, 1'b1, 1'b0, 2'd0, 32'h4008, 32'h01020304, 0, 32'h0);
    chk("sd_be_lit", 32'(last_be), 32'hF);
    run_op(1'b1, 32'h130, 32'h00017083, 3'd7, 1'b0, 1'b1, 2'd2, 32'h77, 32'h0, 0, 32'h0);
    run_op(1'b0, 32'h134, 32'h00010083, 3'd1, 1'b0, 1'b1, 2'd1, 32'h4000, 32'h0, 0, 32'h0);

    // Reset asserted while a load is outstanding
    i_insn_vld = 1'b1; i_pc = 32'h138; i_instr = 32'h00012083; i_ld_en = 3'd3;
    i_lsu_wren = 1'b0; i_rd_wren = 1'b1; i_alu_data = 32'h6000; exp_stall = 1'b1;
    @(posedge i_clk); #1;
    chk("mid_req_up", 32'(o_dmem_req), 32'd1);
    mon_en = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_req", 32'(o_dmem_req), 32'd0);
    chk("mid_rst_instr", o_instr, 32'h00000013);
    i_insn_vld = 1'b0; i_ld_en = 3'd0; i_rd_wren = 1'b0;
    @(negedge i_clk); i_rst = 1'b0;
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'hFFFFFFFF;
    @(posedge i_clk); #1;
    i_dmem_ack = 1'b0;
    chk("stale_ack_vld", 32'(o_insn_vld), 32'd0);
    chk("stale_ack_req", 32'(o_dmem_req), 32'd0);
    chk("stale_ack_ld", o_ld_data, 32'h0);
    mon_en = 1'b1;
    run_op(1'b1, 32'h200, 32'h00100093, 3'd0, 1'b0, 1'b1, 2'd1, 32'h1, 32'h0, 0, 32'h0);
    chk("post_rst_instr", o_instr, 32'h00100093);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
